// File: rtl/dm_byte_lane.sv
// rtl/dm_byte_lane.sv - data memory byte-lane stage: word/half/byte stores, extended loads, access error flag
// Optional trace of committed stores enabled by defining DM_TRACE_EN.
module dm_byte_lane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        addr_err
);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] widx;
  logic [31:0]       cur;
  logic [31:0]       merged;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic              align_err;
  logic              range_err;

  assign widx     = addr[ADDR_W+1:2];
  assign cur      = mem[widx];
  assign half_sel = addr[1] ? cur[31:16] : cur[15:0];
  assign byte_sel = cur[{addr[1:0], 3'b000} +: 8];

  always_comb begin
    align_err = 1'b0;
    range_err = |addr[31:ADDR_W+2];
    case (mem_op)
      3'b000:         align_err = |addr[1:0];
      3'b001, 3'b010: align_err = addr[0];
      3'b011, 3'b100: align_err = 1'b0;
      default:        align_err = 1'b1;
    endcase
    addr_err = align_err | range_err;
  end

  // Merge store data into the current word so untouched lanes keep their value.
  always_comb begin
    merged = cur;
    case (mem_op)
      3'b000: merged = wdata;
      3'b001, 3'b010: begin
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      3'b011, 3'b100: merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      default: merged = cur;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (!addr_err) begin
      case (mem_op)
        3'b000:  rdata = cur;
        3'b001:  rdata = {{16{half_sel[15]}}, half_sel};
        3'b010:  rdata = {16'h0000, half_sel};
        3'b011:  rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  rdata = {24'h000000, byte_sel};
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (mem_write && !addr_err) begin
      mem[widx] <= merged;
`ifdef DM_TRACE_EN
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
`endif
    end
  end

`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule
